// File: rtl/if_pkg.sv
// Shared fetch/decode types and constants.
// Imported by the fetch queue and its storage.
package if_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic        adel;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] RESET_PC   = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;
  localparam logic [31:0] NOP_INSTR  = 32'h0;

endpackage

// File: rtl/fetch_queue_mem.sv
// Fetch queue storage: one write port, one async read port.
// Cleared on rst so the idle head reads as pc 0 after reset.
module fetch_queue_mem
  import if_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [PTR_W-1:0]   waddr,
  input  fetch_entry_t       wdata,
  input  logic [PTR_W-1:0]   raddr,
  output fetch_entry_t       rdata
);

  fetch_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_fetch_queue.sv
// IF/ID decoupling queue: FWFT, flushable,
// no full-bypass and no empty-bypass.
module if_id_fetch_queue
  import if_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_instr,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_pc_add_4,
  output logic [31:0]      out_instr,
  output logic             out_adel,
  input  logic             out_ready,
  output logic [PTR_W:0]   count
);

  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  logic           empty;
  logic           full;
  logic           push;
  logic           pop;
  logic           in_adel;
  fetch_entry_t   wdata;
  fetch_entry_t   head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign count     = wr_ptr - rd_ptr;

  // flush squashes both sides of the handshake
  assign push = in_valid && !full && !flush;
  assign pop  = !empty && out_ready && !flush;

  assign in_adel     = |in_pc[1:0];
  assign wdata.pc    = in_pc;
  assign wdata.adel  = in_adel;
  assign wdata.instr = in_adel ? NOP_INSTR : in_instr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  fetch_queue_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (push),
    .waddr (wr_ptr[PTR_W-1:0]),
    .wdata (wdata),
    .raddr (rd_ptr[PTR_W-1:0]),
    .rdata (head)
  );

  assign out_pc       = head.pc;
  assign out_pc_add_4 = head.pc + 32'd4;
  assign out_adel     = !empty && head.adel;
  assign out_instr    = (empty || head.adel) ? NOP_INSTR
                                             : head.instr;

endmodule
